// File: rtl/counter_sched.sv
// Round-robin scheduler that lends one external up-counter to NREQ timed-interval requesters.
// Optional RUN-state watchdog is compiled in with the macro COUNTER_SCHED_WDOG_EN.
module counter_sched #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 4,
  parameter int WDOG_LIMIT = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || WDOG_LIMIT < 1 || WDOG_LIMIT >= 2 ** (WIDTH + 1)) begin : g_param_check
    $error("counter_sched: NREQ must be 2..8 and WDOG_LIMIT must fit in WIDTH+1 bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] len_arr [NREQ];
  logic [IW-1:0]    pick, cand;
  logic             pick_vld;

`ifdef COUNTER_SCHED_WDOG_EN
  localparam logic [WIDTH:0] WDOG_LAST = (WIDTH + 1)'(WDOG_LIMIT - 1);
  logic [WIDTH:0] wdog_q, wdog_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) len_arr[i] = len[i*WIDTH +: WIDTH];
  end

  // Scan downward so the nearest requester after rr_ptr_q is the last (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state value and output is defaulted first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    target_d = target_q;
    grant    = '0;
    done     = '0;
    busy     = (state_q != S_IDLE);
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef COUNTER_SCHED_WDOG_EN
    wdog_d   = wdog_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_GRANT;
          idx_d    = pick;
          target_d = len_arr[pick];
`ifdef COUNTER_SCHED_WDOG_EN
          wdog_d   = '0;
`endif
        end
      end
      S_GRANT: begin
        grant[idx_q] = 1'b1;
        cnt_clr      = 1'b1;
        if (!req[idx_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = idx_q;
        end else begin
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        grant[idx_q] = 1'b1;
        // Enable stops the counter exactly on target, so it never overshoots.
        cnt_en       = (cnt_value != target_q);
`ifdef COUNTER_SCHED_WDOG_EN
        wdog_d       = wdog_q + 1'b1;
`endif
        if (!req[idx_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = idx_q;
        end else if (cnt_value == target_q) begin
          state_d  = S_DONE;
`ifdef COUNTER_SCHED_WDOG_EN
        end else if (wdog_q == WDOG_LAST) begin
          state_d  = S_IDLE;
          rr_ptr_d = idx_q;
          err_d    = 1'b1;
`endif
        end
      end
      S_DONE: begin
        done[idx_q] = 1'b1;
        rr_ptr_d    = idx_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      target_q <= target_d;
    end
  end

`ifdef COUNTER_SCHED_WDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed scenarios with literal expectations plus
// randomized requesters, all compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_counter_sched;
  localparam int NREQ       = 4;
  localparam int WIDTH      = 4;
  localparam int WDOG_LIMIT = 17;
`ifdef COUNTER_SCHED_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic                  clk   = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*WIDTH-1:0] len   = '0;
  logic [NREQ-1:0]       grant, done;
  logic                  busy, cnt_clr, cnt_en, err;
  logic [WIDTH-1:0]      cnt_value;
  logic [WIDTH-1:0]      cnt_q     = '0;
  logic                  cnt_stuck = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .grant(grant), .done(done),
    .busy(busy), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_value(cnt_value), .err(err)
  );

  always #5 clk = ~clk;

  // Shared 4-bit counter with synchronous clear; cnt_stuck models a counter frozen at zero.
  always @(posedge clk) begin
    if (cnt_stuck)    cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_en)  cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_value = cnt_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
  endtask

  // Transaction model: who owns the counter, how long since the grant, and the pending done pulse.
  int               m_owner    = -1;
  int               m_done_who = -1;
  int               m_age      = 0;
  int               m_ptr      = NREQ - 1;
  logic [WIDTH-1:0] m_tgt      = '0;
  bit               m_err      = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1; m_done_who = -1; m_age = 0; m_ptr = NREQ - 1; m_tgt = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr = m_owner; m_owner = -1;
        end else if (m_age >= 1 && cnt_value == m_tgt) begin
          m_done_who = m_owner; m_owner = -1;
        end else if (WDOG_ON && m_age == WDOG_LIMIT) begin
          m_err = 1'b1; m_ptr = m_owner; m_owner = -1;
        end else begin
          m_age++;
        end
      end else if (m_done_who >= 0) begin
        m_ptr = m_done_who; m_done_who = -1;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_tgt   = len[m_owner*WIDTH +: WIDTH];
            m_age   = 0;
          end
        end
      end
    end
  end

  logic [NREQ-1:0] exp_grant, exp_done;
  logic            exp_busy, exp_clr, exp_en;

  always @(negedge clk) begin
    exp_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    exp_done  = (m_done_who >= 0) ? NREQ'(1 << m_done_who) : '0;
    exp_busy  = (m_owner >= 0) || (m_done_who >= 0);
    exp_clr   = (m_owner >= 0) && (m_age == 0);
    exp_en    = (m_owner >= 0) && (m_age >= 1) && (cnt_value != m_tgt);
    check("cyc_grant",   32'(grant),   32'(exp_grant));
    check("cyc_done",    32'(done),    32'(exp_done));
    check("cyc_busy",    32'(busy),    32'(exp_busy));
    check("cyc_cnt_clr", 32'(cnt_clr), 32'(exp_clr));
    check("cyc_cnt_en",  32'(cnt_en),  32'(exp_en));
    check("cyc_err",     32'(err),     32'(m_err));
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One isolated request from an idle block; measures latency, enable and clear counts.
  task automatic run_one(input int i, input int l, input int exp_lat, input int exp_en);
    int g_c, d_c, en_n, clr_n, g_n;
    g_c = -1; d_c = -1; en_n = 0; clr_n = 0; g_n = 0;
    len[i*WIDTH +: WIDTH] = WIDTH'(l);
    req[i] = 1'b1;
    for (int c = 0; c < 40 && d_c < 0; c++) begin
      next_cycle();
      if (grant[i]) begin
        if (g_c < 0) g_c = c;
        g_n++;
      end
      if (cnt_en)  en_n++;
      if (cnt_clr) clr_n++;
      if (done[i]) begin
        d_c    = c;
        req[i] = 1'b0;
      end
    end
    check("grant_latency",  g_c,         0);
    check("done_latency",   d_c - g_c,   exp_lat);
    check("cnt_en_cycles",  en_n,        exp_en);
    check("cnt_clr_cycles", clr_n,       1);
    check("grant_cycles",   g_n,         exp_lat);
    next_cycle();
    check("busy_after_done", 32'(busy),  0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    int exp_order[8] = '{0, 2, 0, 2, 3, 0, 1, 2};
    logic [NREQ-1:0] prev;
    bit found, d_seen, e_seen;
    int g_c, drop_c, err_c;

    // Reset state
    next_cycle();
    next_cycle();
    check("rst_grant",   32'(grant),   0);
    check("rst_done",    32'(done),    0);
    check("rst_busy",    32'(busy),    0);
    check("rst_cnt_clr", 32'(cnt_clr), 0);
    check("rst_err",     32'(err),     0);
    reset = 1'b1;
    next_cycle();

    // Single requests: typical, zero and maximum lengths
    run_one(1, 3, 5, 3);
    run_one(0, 0, 2, 0);
    run_one(2, 15, 17, 15);

    // Reset in the middle of RUN
    len[1*WIDTH +: WIDTH] = 4'd5;
    req[1] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      next_cycle();
      if (grant[1] && cnt_en) found = 1'b1;
    end
    check("midrst_reached_run", found, 1);
    reset = 1'b0;
    req   = '0;
    #1;
    check("midrst_grant",   32'(grant),   0);
    check("midrst_done",    32'(done),    0);
    check("midrst_busy",    32'(busy),    0);
    check("midrst_cnt_clr", 32'(cnt_clr), 0);
    check("midrst_cnt_en",  32'(cnt_en),  0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    repeat (3) next_cycle();
    check("midrst_idle_busy",  32'(busy),  0);
    check("midrst_idle_grant", 32'(grant), 0);

    // Round robin
    reset_pulse();
    len  = {4'd1, 4'd1, 4'd1, 4'd1};
    req  = 4'b0101;
    prev = '0;
    for (int c = 0; c < 300 && order.size() < 8; c++) begin
      next_cycle();
      if (grant != '0 && prev == '0) begin
        order.push_back(onehot_idx(grant));
        if (order.size() == 4) req = 4'b1111;
      end
      prev = grant;
    end
    for (int k = 0; k < 8; k++)
      check($sformatf("rr_order_%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
    req = '0;
    repeat (4) next_cycle();

    // Abort at counter value 4, pending requester picked up after one IDLE cycle
    reset_pulse();
    len[2*WIDTH +: WIDTH] = 4'd9;
    len[3*WIDTH +: WIDTH] = 4'd1;
    req    = 4'b1100;
    found  = 1'b0;
    d_seen = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      next_cycle();
      if (done[2]) d_seen = 1'b1;
      if (grant[2] && !cnt_clr && cnt_value == 4'd4) begin
        found  = 1'b1;
        req[2] = 1'b0;
      end
    end
    check("abort_reached_value4", found, 1);
    next_cycle();
    if (done[2]) d_seen = 1'b1;
    check("abort_grant_drop", 32'(grant), 0);
    check("abort_busy_idle",  32'(busy),  0);
    next_cycle();
    check("abort_next_grant", 32'(grant), 32'(4'b1000));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      next_cycle();
      if (done[2]) d_seen = 1'b1;
      if (done[3]) begin
        found  = 1'b1;
        req[3] = 1'b0;
      end
    end
    check("abort_no_done2",   d_seen, 0);
    check("abort_req3_done",  found,  1);
    repeat (2) next_cycle();

    // Stuck counter: watchdog behaviour
    reset_pulse();
    cnt_stuck = 1'b1;
    len[0 +: WIDTH] = 4'd5;
    req[0] = 1'b1;
    g_c = -1; drop_c = -1; err_c = -1; d_seen = 1'b0; e_seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      next_cycle();
      if (grant[0] && g_c < 0) g_c = c;
      if (g_c >= 0 && !grant[0] && drop_c < 0) drop_c = c;
      if (err && err_c < 0) err_c = c;
      if (err) e_seen = 1'b1;
      if (done[0]) d_seen = 1'b1;
    end
    check("wdog_grant_latency", g_c, 0);
    check("wdog_no_done",       d_seen, 0);
`ifdef COUNTER_SCHED_WDOG_EN
    check("wdog_drop_cycle", drop_c - g_c, WDOG_LIMIT + 1);
    check("wdog_err_cycle",  err_c - g_c,  WDOG_LIMIT + 1);
`else
    check("wdog_never_drops", drop_c, -1);
    check("wdog_err_low",     e_seen, 0);
    check("wdog_grant_held",  32'(grant), 32'(4'b0001));
`endif
    req       = '0;
    cnt_stuck = 1'b0;
    repeat (3) next_cycle();

    // Randomized requesters; every cycle is checked against the model
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            len[i*WIDTH +: WIDTH] = ($urandom_range(5) == 0) ? WIDTH'($urandom_range(15))
                                                             : WIDTH'($urandom_range(4));
          end
        end else if (done[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(40) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(7) == 0) len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(15));
      end
    end
    req = '0;
    repeat (20) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one external up-counter (the existing 4-bit counter datapath) between NREQ requesters.
- Each requester asks for a timed interval of `len` counts.
- The scheduler clears and enables the counter, watches its value, and reports completion to the granted requester.
- Sits between CPU-side timing clients and the shared counter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, counter and length width in bits
- WDOG_LIMIT, 17, RUN-state cycle limit before watchdog release (used only with the optional feature)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request level; held high until done or abort
- len  input  NREQ*WIDTH  per-requester target count; slice i is bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot, registered; high for the granted requester from GRANT through RUN
- done  output  NREQ  one-cycle completion pulse to the granted requester
- busy  output  1  high in every state except IDLE
- cnt_clr  output  1  counter clear request (counter treats it as a synchronous clear)
- cnt_en  output  1  counter increment enable
- cnt_value  input  WIDTH  current counter value
- err  output  1  one-cycle watchdog pulse; constant 0 when the optional feature is compiled out

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE
  - grant=0, done=0, busy=0, cnt_clr=0, err=0
  - rr_ptr=NREQ-1, so requester 0 has highest priority first
- States: IDLE, GRANT, RUN, DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching from rr_ptr+1 upward, wrapping mod NREQ.
  - Latch idx and target=len[idx].
  - Next state GRANT. Otherwise stay in IDLE.
- GRANT (exactly 1 cycle):
  - grant[idx]=1, cnt_clr=1.
  - Next state RUN, or IDLE if req[idx]=0 (abort).
- RUN:
  - grant[idx]=1.
  - cnt_en is combinational: 1 when cnt_value!=target, 0 otherwise. The counter therefore stops at target and never overshoots.
  - When cnt_value==target, next state DONE.
  - RUN lasts target+1 cycles (values 0..target); cnt_en is high for exactly target cycles.
- DONE (exactly 1 cycle):
  - done[idx]=1, grant=0, cnt_en=0.
  - rr_ptr<=idx. Next state IDLE.
  - req is ignored in DONE, so at least one IDLE cycle separates consecutive grants.
- Latency:
  - grant rises one cycle after req is sampled in IDLE.
  - done pulses target+2 cycles after grant rises.
- Abort:
  - req[idx] low at any edge in GRANT or RUN → next state IDLE, grant drops, no done pulse, rr_ptr<=idx.
- Other cases:
  - target=0: RUN lasts 1 cycle, cnt_en never asserts, then DONE.
  - len and req changes of non-granted requesters are ignored while busy.
  - target is frozen at grant; changes to len[idx] during RUN have no effect.
  - Multiple simultaneous requests: exactly one grant; the remaining requesters are served on later passes in round-robin order.
  - Reset asserted mid-operation: outputs go to reset values immediately; the counter is not cleared by this block.

Optional Feature:
- Macro: COUNTER_SCHED_WDOG_EN.
- Defined:
  - A WIDTH+1-bit watchdog counts RUN cycles and clears on entry to GRANT.
  - If it reaches WDOG_LIMIT while still in RUN: err=1 for one cycle, grant drops, next state IDLE, no done, rr_ptr<=idx.
- Undefined:
  - No watchdog logic; err tied to 0.
  - RUN persists until match or abort.

Test Plan:
- Reset: reset low during RUN with grant[1]=1 → grant, done, busy, cnt_clr and cnt_en all 0 immediately; after release with req=0 the block stays in IDLE with busy=0.
- Single request, len[1]=3:
  - req[1]=1 → grant[1] rises the next cycle and cnt_clr is high for 1 cycle.
  - cnt_en is high for 3 cycles (values 0,1,2).
  - done[1] pulses 5 cycles after grant rises; busy falls with it.
- Round robin: after reset, req=4'b0101 held, each requester re-raising req after its done → grant order 0, 2, 0, 2; then req=4'b1111 → next grants 3, 0, 1, 2.
- len[0]=0, req[0]=1 → grant[0] for 2 cycles, cnt_en never high, done[0] pulses 2 cycles after grant rises.
- Abort: len[2]=9, req[2] dropped at RUN value 4 → grant[2] low the next cycle, no done pulse, and a pending req[3] is granted after one IDLE cycle.
- Watchdog: cnt_value held at 0, len[0]=5:
  - Macro defined → err pulses after 17 RUN cycles, grant drops, no done.
  - Macro undefined → grant[0] still high after 40 cycles and err stays 0.
